// File: rtl/periph_resp_mux.sv
// periph_resp_mux: AHB-Lite data-phase response stage for the uncore bus.
// Registers the one-hot address-phase select and muxes the selected
// peripheral's HRDATA/HREADY/HRESP back to the manager. It also produces a
// two-cycle error response for unmapped or multi-hit accesses and for
// peripherals that stall longer than TIMEOUT cycles.
//
// Handshake: a transfer is accepted on every cycle where AddrValid=1 and
// HREADY=1 (Accept). The accepted address phase becomes the data phase on the
// next cycle, so the completing data phase and the next address phase overlap.
module periph_resp_mux #(
  parameter int NPERIPH = 8,
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    AddrValid,
  input  logic [NPERIPH-1:0]      SelA,
  input  logic [NPERIPH-1:0]      HREADYp,
  input  logic [NPERIPH-1:0]      HRESPp,
  input  logic [NPERIPH*XLEN-1:0] HRDATAp,
  output logic                    HREADY,
  output logic                    HRESP,
  output logic [XLEN-1:0]         HRDATA,
  output logic [NPERIPH-1:0]      SelD,
  output logic                    TimeoutEvt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  // A 16-bit counter covers the full legal TIMEOUT range.
  localparam int             CW      = 16;
  localparam logic [CW-1:0]  TMO     = CW'(TIMEOUT);
  localparam logic [CW-1:0]  CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [NPERIPH-1:0] sel_q, sel_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tevt_q, tevt_d;

  logic               sel_onehot;
  logic               rdy_mux, resp_mux;
  logic [XLEN-1:0]    rdata_mux;
  logic               hready_c, hresp_c;
  logic [XLEN-1:0]    hrdata_c;

  // Exactly one select bit set: nonzero and no second bit.
  assign sel_onehot = (SelA != '0) && ((SelA & (SelA - 1'b1)) == '0);

  // AND-OR mux over the registered select; yields zero when sel_q is zero.
  always_comb begin
    rdy_mux   = 1'b0;
    resp_mux  = 1'b0;
    rdata_mux = '0;
    for (int i = 0; i < NPERIPH; i++) begin
      rdy_mux   = rdy_mux  | (HREADYp[i] & sel_q[i]);
      resp_mux  = resp_mux | (HRESPp[i]  & sel_q[i]);
      rdata_mux = rdata_mux | (HRDATAp[i*XLEN +: XLEN] & {XLEN{sel_q[i]}});
    end
  end

  // Next-state, stall counting and bus outputs.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    tevt_d   = 1'b0;
    hready_c = 1'b1;
    hresp_c  = 1'b0;
    hrdata_c = '0;

    case (state_q)
      IDLE: begin
      end
      DATA: begin
        hready_c = rdy_mux;
        hresp_c  = resp_mux;
        hrdata_c = rdata_mux;
        if (!rdy_mux) begin
          if (cnt_q == TMO) begin
            // Abandon the peripheral: its late HREADY is never looked at
            // again because the select is dropped here.
            hresp_c = 1'b0;
            state_d = ERR1;
            sel_d   = '0;
            tevt_d  = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ERR1: begin
        hready_c = 1'b0;
        hresp_c  = 1'b1;
        state_d  = ERR2;
        sel_d    = '0;
      end
      ERR2: begin
        hresp_c = 1'b1;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    // Any cycle with HREADY high completes the current phase and samples
    // the next address phase.
    if (hready_c) begin
      if (AddrValid) begin
        if (sel_onehot) begin
          state_d = DATA;
          sel_d   = SelA;
          cnt_d   = '0;
        end else begin
          state_d = ERR1;
          sel_d   = '0;
        end
      end else begin
        state_d = IDLE;
        sel_d   = '0;
      end
    end
  end

  // State, select, stall counter and timeout pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      tevt_q  <= tevt_d;
    end
  end

  assign HREADY     = hready_c;
  assign HRESP      = hresp_c;
  assign HRDATA     = hrdata_c;
  assign SelD       = sel_q;
  assign TimeoutEvt = tevt_q;

endmodule

// File: tb/tb_periph_resp_mux.sv
// Bench for periph_resp_mux: directed transfers, a transaction-level model
// compared against the DUT every cycle, plus literal spot checks.
module tb_periph_resp_mux;

  localparam int NPERIPH = 8;
  localparam int XLEN    = 64;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic                    addr_valid = 1'b0;
  logic [NPERIPH-1:0]      sel_a      = '0;
  logic [NPERIPH-1:0]      hreadyp    = '1;
  logic [NPERIPH-1:0]      hrespp     = '0;
  logic [NPERIPH*XLEN-1:0] hrdatap    = '0;
  logic                    hready, hresp, tevt;
  logic [XLEN-1:0]         hrdata;
  logic [NPERIPH-1:0]      sel_d;

  periph_resp_mux #(.NPERIPH(NPERIPH), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .AddrValid(addr_valid), .SelA(sel_a),
    .HREADYp(hreadyp), .HRESPp(hrespp), .HRDATAp(hrdatap),
    .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata), .SelD(sel_d),
    .TimeoutEvt(tevt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] got,
                     input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Transaction view: who owns the data phase, how long it has waited, and
  // how many error-response cycles are still owed.
  int m_owner    = -1;  // peripheral index in data phase, -1 = none
  int m_waited   = 0;   // stall cycles already spent by m_owner
  int m_err_left = 0;   // 2 = first error cycle, 1 = second
  bit m_evt      = 1'b0;

  function automatic int count_bits(input logic [NPERIPH-1:0] v);
    int n = 0;
    for (int i = 0; i < NPERIPH; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int first_bit(input logic [NPERIPH-1:0] v);
    for (int i = 0; i < NPERIPH; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Compare on the falling edge (inputs are stable), then advance the model
  // to what the next rising edge must produce.
  always @(negedge clk) begin
    logic            e_rdy, e_resp;
    logic [XLEN-1:0] e_data;
    logic [NPERIPH-1:0] e_sel;
    bit              timeout_now;
    timeout_now = 1'b0;
    if (!resetn) begin
      m_owner = -1; m_waited = 0; m_err_left = 0; m_evt = 1'b0;
      chk("rst_hready", XLEN'(hready), XLEN'(1));
      chk("rst_hresp",  XLEN'(hresp),  XLEN'(0));
      chk("rst_hrdata", hrdata,        '0);
      chk("rst_seld",   XLEN'(sel_d),  '0);
      chk("rst_tevt",   XLEN'(tevt),   '0);
    end else begin
      e_sel = '0;
      if (m_err_left == 2) begin
        e_rdy = 1'b0; e_resp = 1'b1; e_data = '0;
      end else if (m_err_left == 1) begin
        e_rdy = 1'b1; e_resp = 1'b1; e_data = '0;
      end else if (m_owner >= 0) begin
        e_sel  = NPERIPH'(1) << m_owner;
        e_data = hrdatap[m_owner*XLEN +: XLEN];
        e_rdy  = hreadyp[m_owner];
        e_resp = hrespp[m_owner];
        if (!hreadyp[m_owner] && m_waited == TIMEOUT) begin
          timeout_now = 1'b1;
          e_resp = 1'b0;
        end
      end else begin
        e_rdy = 1'b1; e_resp = 1'b0; e_data = '0;
      end
      chk("cyc_hready", XLEN'(hready), XLEN'(e_rdy));
      chk("cyc_hresp",  XLEN'(hresp),  XLEN'(e_resp));
      chk("cyc_hrdata", hrdata,        e_data);
      chk("cyc_seld",   XLEN'(sel_d),  XLEN'(e_sel));
      chk("cyc_tevt",   XLEN'(tevt),   XLEN'(m_evt));

      m_evt = 1'b0;
      if (m_err_left == 2) begin
        m_err_left = 1;
        m_owner = -1;
      end else if (timeout_now) begin
        m_owner = -1;
        m_err_left = 2;
        m_evt = 1'b1;
      end else if (!e_rdy) begin
        if (m_waited < 65535) m_waited++;
      end else begin
        m_err_left = 0;
        m_owner = -1;
        if (addr_valid) begin
          if (count_bits(sel_a) == 1) begin
            m_owner = first_bit(sel_a);
            m_waited = 0;
          end else begin
            m_err_left = 2;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr(input logic v, input logic [NPERIPH-1:0] s);
    addr_valid = v;
    sel_a      = s;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < NPERIPH; i++)
      hrdatap[i*XLEN +: XLEN] = {32'h1000_0000 + 32'(i), 32'hA5A5_0000 + 32'(i)};

    // Reset held for three cycles.
    resetn = 1'b0;
    step(); step(); step();
    at_neg();
    chk("reset_hready", XLEN'(hready), XLEN'(1));
    chk("reset_hrdata", hrdata, '0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single read from peripheral 2.
    addr(1'b1, 8'h04);
    step();
    addr(1'b0, 8'h00);
    hrdatap[2*XLEN +: XLEN] = 64'hDEADBEEF_CAFEF00D;
    at_neg();
    chk("read_seld",   XLEN'(sel_d), XLEN'(8'h04));
    chk("read_hready", XLEN'(hready), XLEN'(1));
    chk("read_hresp",  XLEN'(hresp), XLEN'(0));
    chk("read_hrdata", hrdata, 64'hDEADBEEF_CAFEF00D);
    step();

    // Unmapped (zero select) then multi-hit: two-cycle error, then idle.
    for (int r = 0; r < 2; r++) begin
      addr(1'b1, (r == 0) ? 8'h00 : 8'h06);
      step();
      addr(1'b0, 8'h00);
      at_neg();
      chk("err1_hready", XLEN'(hready), XLEN'(0));
      chk("err1_hresp",  XLEN'(hresp), XLEN'(1));
      step();
      at_neg();
      chk("err2_hready", XLEN'(hready), XLEN'(1));
      chk("err2_hresp",  XLEN'(hresp), XLEN'(1));
      step();
      at_neg();
      chk("post_err_hresp", XLEN'(hresp), XLEN'(0));
      step();
    end

    // Back-to-back: 0x01 then 0x80 with no bubble.
    addr(1'b1, 8'h01);
    step();
    addr(1'b1, 8'h80);
    at_neg();
    chk("b2b_seld0",   XLEN'(sel_d), XLEN'(8'h01));
    chk("b2b_hready0", XLEN'(hready), XLEN'(1));
    step();
    addr(1'b0, 8'h00);
    at_neg();
    chk("b2b_seld1",   XLEN'(sel_d), XLEN'(8'h80));
    chk("b2b_hready1", XLEN'(hready), XLEN'(1));
    step();

    // Timeout on peripheral 3: five stalled data cycles, then abort.
    hreadyp[3] = 1'b0;
    addr(1'b1, 8'h08);
    step();
    addr(1'b0, 8'h00);
    for (int k = 0; k <= TIMEOUT; k++) begin
      at_neg();
      chk("tmo_stall_hready", XLEN'(hready), XLEN'(0));
      chk("tmo_stall_seld",   XLEN'(sel_d), XLEN'(8'h08));
      step();
    end
    hreadyp[3] = 1'b1;  // late ready from the abandoned peripheral
    at_neg();
    chk("tmo_err1_hready", XLEN'(hready), XLEN'(0));
    chk("tmo_err1_hresp",  XLEN'(hresp), XLEN'(1));
    chk("tmo_evt",         XLEN'(tevt), XLEN'(1));
    step();
    at_neg();
    chk("tmo_err2_hready", XLEN'(hready), XLEN'(1));
    chk("tmo_err2_evt",    XLEN'(tevt), XLEN'(0));
    step();
    at_neg();
    chk("tmo_idle_hresp", XLEN'(hresp), XLEN'(0));
    chk("tmo_idle_seld",  XLEN'(sel_d), '0);
    step();

    // Stall 3 cycles then release; next transfer must restart the count.
    hreadyp[1] = 1'b0;
    addr(1'b1, 8'h02);
    step();
    addr(1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("stall_hready", XLEN'(hready), XLEN'(0));
      step();
    end
    hreadyp[1] = 1'b1;
    addr(1'b1, 8'h02);
    at_neg();
    chk("release_hready", XLEN'(hready), XLEN'(1));
    step();
    addr(1'b0, 8'h00);
    hreadyp[1] = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      at_neg();
      chk("restart_seld", XLEN'(sel_d), XLEN'(8'h02));
      chk("restart_evt",  XLEN'(tevt), XLEN'(0));
      step();
    end
    hreadyp[1] = 1'b1;
    at_neg();
    chk("restart_done_hready", XLEN'(hready), XLEN'(1));
    chk("restart_done_hresp",  XLEN'(hresp), XLEN'(0));
    step();

    // Peripheral error passes through unchanged (peripheral 5).
    addr(1'b1, 8'h20);
    step();
    addr(1'b0, 8'h00);
    hreadyp[5] = 1'b0; hrespp[5] = 1'b1;
    at_neg();
    chk("perr1_hresp",  XLEN'(hresp), XLEN'(1));
    chk("perr1_hready", XLEN'(hready), XLEN'(0));
    step();
    hreadyp[5] = 1'b1;
    at_neg();
    chk("perr2_hresp",  XLEN'(hresp), XLEN'(1));
    chk("perr2_hready", XLEN'(hready), XLEN'(1));
    step();
    hrespp[5] = 1'b0;

    // Reset asserted during ERR1 takes effect within the cycle.
    addr(1'b1, 8'h00);
    step();
    addr(1'b0, 8'h00);
    #1;
    chk("pre_rst_hready", XLEN'(hready), XLEN'(0));
    resetn = 1'b0;
    #1;
    chk("abort_hready", XLEN'(hready), XLEN'(1));
    chk("abort_hresp",  XLEN'(hresp), XLEN'(0));
    step(); step();
    resetn = 1'b1;
    at_neg();
    chk("after_rst_hresp", XLEN'(hresp), XLEN'(0));
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
